// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: control inputs and fetch results of the fetch unit.
// master = processor control / decode side, slave = fetch unit.
interface instr_fetch_unit_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int OFFSET_WIDTH = 8
);
  logic                    start;
  logic                    stall;
  logic                    branch_taken;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic                    jump;
  logic [INSTR_WIDTH-1:0]  instr;
  logic [ADDR_WIDTH-1:0]   instr_pc;
  logic                    instr_valid;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    halted;
  logic                    fault;

  modport master (
    output start, stall, branch_taken, branch_offset, jump,
    input  instr, instr_pc, instr_valid, pc, halted, fault
  );

  modport slave (
    input  start, stall, branch_taken, branch_offset, jump,
    output instr, instr_pc, instr_valid, pc, halted, fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, synchronous instruction memory, relative redirects.
// Define IFU_PROG_LOAD_EN to add the prog_* program-load write port.
module instr_fetch_unit #(
  parameter int                    INSTR_WIDTH  = 16,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    DEPTH        = 32,
  parameter int                    OFFSET_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [3:0]            HALT_OPCODE  = 4'b1110,
  parameter string                 INIT_FILE    = ""
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef IFU_PROG_LOAD_EN
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
`endif
  instr_fetch_unit_if.slave      bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t state, state_nx;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_nx;
  logic [ADDR_WIDTH-1:0]  ipc_q, ipc_nx;
  logic                   valid_q, valid_nx;
  logic                   halted_q, halted_nx;
  logic                   fault_q, fault_nx;
  logic                   fetch;

  logic [3:0]            opcode;
  logic                  is_halt;
  logic                  pc_oob;
  logic                  take_jump;
  logic                  take_branch;
  logic [ADDR_WIDTH-1:0] jmp_off;
  logic [ADDR_WIDTH-1:0] br_off;
  logic [IW-1:0]         rd_addr;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign opcode      = instr_q[INSTR_WIDTH-1 -: 4];
  assign is_halt     = valid_q && (opcode == HALT_OPCODE);
  assign pc_oob      = {1'b0, pc_q} >= DEPTH_C;
  assign take_jump   = bus.jump && valid_q;
  assign take_branch = bus.branch_taken && valid_q;
  assign rd_addr     = pc_q[IW-1:0];

  // Offsets are sign-extended, then truncated to the PC width.
  assign jmp_off = ADDR_WIDTH'(signed'(instr_q[7:0]));
  assign br_off  = ADDR_WIDTH'(signed'(bus.branch_offset));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      pc_q     <= pc_nx;
      ipc_q    <= ipc_nx;
      valid_q  <= valid_nx;
      halted_q <= halted_nx;
      fault_q  <= fault_nx;
      if (fetch) instr_q <= mem[rd_addr];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HALT: begin
        if (bus.start) state_nx = FETCH;
      end
      FETCH: begin
        if (!bus.stall && !take_jump && !take_branch &&
            (is_halt || pc_oob))
          state_nx = HALT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_nx     = pc_q;
    ipc_nx    = ipc_q;
    valid_nx  = valid_q;
    halted_nx = halted_q;
    fault_nx  = fault_q;
    fetch     = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          pc_nx     = RESET_PC;
          halted_nx = 1'b0;
        end
      end
      FETCH: begin
        if (bus.stall) begin
          pc_nx = pc_q;
        end else if (take_jump) begin
          pc_nx    = ipc_q + jmp_off;
          valid_nx = 1'b0;
        end else if (take_branch) begin
          pc_nx    = ipc_q + br_off;
          valid_nx = 1'b0;
        end else if (is_halt) begin
          valid_nx  = 1'b0;
          halted_nx = 1'b1;
        end else if (pc_oob) begin
          fault_nx  = 1'b1;
          valid_nx  = 1'b0;
          halted_nx = 1'b1;
        end else begin
          fetch    = 1'b1;
          ipc_nx   = pc_q;
          valid_nx = 1'b1;
          pc_nx    = pc_q + 1'b1;
        end
      end
      default: begin
        valid_nx = 1'b0;
      end
    endcase
  end

`ifdef IFU_PROG_LOAD_EN
  // Reads on the same edge see the old word.
  always_ff @(posedge clk) begin
    if (prog_we && ({1'b0, prog_addr} < DEPTH_C))
      mem[prog_addr[IW-1:0]] <= prog_data;
  end
`endif

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random fetch/redirect/halt checks
// against a rule-level reference model of the fetch unit.
module tb_instr_fetch_unit;
  localparam int IW = 16;
  localparam int AW = 6;
  localparam int DP = 32;
  localparam int OW = 8;
  localparam int RPC = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW)
  ) bus ();

`ifdef IFU_PROG_LOAD_EN
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
`endif

  instr_fetch_unit #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DP),
    .OFFSET_WIDTH(OW), .RESET_PC(AW'(RPC))
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef IFU_PROG_LOAD_EN
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
`endif
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 fetching, 2 halted.
  int img [64];
  int m_mode, m_pc, m_ipc, m_instr;
  bit m_valid, m_halted, m_fault;

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RPC; m_ipc = 0; m_instr = 0;
    m_valid = 0; m_halted = 0; m_fault = 0;
  endtask

  task automatic model_step();
    int off;
    if (m_mode != 1) begin
      if (bus.start) begin
        m_mode = 1; m_pc = RPC; m_halted = 0;
      end
    end else if (bus.stall) begin
      m_mode = 1;
    end else if (bus.jump && m_valid) begin
      off = sx8(m_instr % 256);
      m_pc = (m_ipc + off) & 63;
      m_valid = 0;
    end else if (bus.branch_taken && m_valid) begin
      off = sx8(int'(bus.branch_offset));
      m_pc = (m_ipc + off) & 63;
      m_valid = 0;
    end else if (m_valid && (m_instr / 4096) == 14) begin
      m_mode = 2; m_valid = 0; m_halted = 1;
    end else if (m_pc >= DP) begin
      m_fault = 1; m_mode = 2; m_valid = 0; m_halted = 1;
    end else begin
      m_instr = img[m_pc]; m_ipc = m_pc; m_valid = 1;
      m_pc = (m_pc + 1) % 64;
    end
`ifdef IFU_PROG_LOAD_EN
    if (prog_we && int'(prog_addr) < DP) img[prog_addr] = int'(prog_data);
`endif
  endtask

  task automatic compare_all();
    check("instr", 32'(bus.instr), 32'(m_instr));
    check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("pc", 32'(bus.pc), 32'(m_pc));
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("fault", 32'(bus.fault), 32'(m_fault));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic load(input int a, input int v);
    dut.mem[a] = IW'(v);
    img[a] = v;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.branch_offset = '0; bus.jump = 0;
  endtask

  initial begin
    idle_inputs();
`ifdef IFU_PROG_LOAD_EN
    prog_we = 0; prog_addr = '0; prog_data = '0;
`endif
    for (int i = 0; i < 64; i++) img[i] = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 0;

    load(0, 'h0440); load(1, 'h0441); load(2, 'h0682);
    load(3, 'h0683); load(4, 'h1234); load(5, 'hE000);
    for (int i = 6; i < DP; i++) load(i, 'h1000 + i);
    load(20, 'h2303);

    bus.start = 1; tick(); bus.start = 0;
    check("no_valid_after_1_edge", 32'(bus.instr_valid), 0);
    tick();
    check("first_instr", 32'(bus.instr), 'h0440);
    check("first_ipc", 32'(bus.instr_pc), 0);
    tick();
    check("seq_instr1", 32'(bus.instr), 'h0441);
    tick();
    check("seq_instr2", 32'(bus.instr), 'h0682);
    bus.stall = 1;
    repeat (3) tick();
    check("stall_instr", 32'(bus.instr), 'h0682);
    check("stall_pc", 32'(bus.pc), 3);
    check("stall_valid", 32'(bus.instr_valid), 1);
    bus.stall = 0;
    tick();
    check("resume_instr", 32'(bus.instr), 'h0683);
    repeat (2) tick();
    check("halt_word_ipc", 32'(bus.instr_pc), 5);
    tick();
    check("halt_halted", 32'(bus.halted), 1);
    check("halt_valid", 32'(bus.instr_valid), 0);
    repeat (2) tick();
    bus.start = 1; tick(); bus.start = 0;
    check("restart_halted", 32'(bus.halted), 0);
    check("restart_pc", 32'(bus.pc), RPC);

    repeat (3) tick();
    bus.branch_taken = 1; bus.branch_offset = 8'd12;
    tick();
    bus.branch_taken = 0;
    check("br_bubble", 32'(bus.instr_valid), 0);
    tick();
    check("br_ipc14", 32'(bus.instr_pc), 14);
    bus.branch_taken = 1; bus.branch_offset = 8'd6;
    tick();
    bus.branch_taken = 0;
    tick();
    check("br_ipc20", 32'(bus.instr_pc), 20);
    check("br_instr20", 32'(bus.instr), 'h2303);
    bus.jump = 1; bus.branch_taken = 1; bus.branch_offset = 8'd1;
    tick();
    bus.jump = 0; bus.branch_taken = 0;
    tick();
    check("jump_ipc23", 32'(bus.instr_pc), 23);
    for (int i = 0; i < 20 && !m_halted; i++) tick();
    check("oob_fault", 32'(bus.fault), 1);
    check("oob_halted", 32'(bus.halted), 1);

    bus.start = 1; tick(); bus.start = 0;
    repeat (3) tick();
    bus.branch_taken = 1; bus.branch_offset = 8'hFD;
    tick();
    bus.branch_taken = 0;
    check("wrap_pc63", 32'(bus.pc), 63);
    tick();
    check("wrap_halted", 32'(bus.halted), 1);
    check("fault_sticky", 32'(bus.fault), 1);

    for (int i = 0; i < DP; i++)
      load(i, ($urandom_range(0, 7) == 0) ? ('hE000 | $urandom_range(0, 'hFFF))
                                          : ($urandom_range(0, 'hDFFF)));
    for (int n = 0; n < 600; n++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.jump = ($urandom_range(0, 7) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.branch_offset = OW'($urandom);
      bus.start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 0;
      end
      tick();
    end
    idle_inputs();

    bus.start = 1; tick(); bus.start = 0;
    repeat (3) tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    check("async_rst_instr", 32'(bus.instr), 0);
    check("async_rst_valid", 32'(bus.instr_valid), 0);
    compare_all();
    @(negedge clk);
    rst = 0;

`ifdef IFU_PROG_LOAD_EN
    prog_we = 1; prog_addr = '0; prog_data = 16'h4F0F;
    tick();
    prog_we = 0;
    bus.start = 1; tick(); bus.start = 0;
    tick();
    check("prog_first_instr", 32'(bus.instr), 'h4F0F);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
